lock_entry_ctrl: RTL and testbench
==================================

# lock_entry_ctrl

Sequential controller downstream of the keypad encoder. It consumes the encoder's 4-bit digit code (0 = no key, 1..9 = key) plus enter/clear buttons, and assembles a 4-digit entry. It compares the entry against a stored code and drives unlock/alarm outputs. It supplies four 4-bit digit codes, one to each 7-segment decoder instance, using the decoder's glyphs: 4'hF blank, 4'hE "E", 4'hA "A", 4'h0 "0".

## Interface
- DEFAULT_CODE, 16'h1234: code after reset; digit3 in [15:12].
- MAX_TRIES, 3: consecutive failed checks before lockout (≥1).
- FAIL_CYCLES, 25_000_000: duration of error display.
- LOCKOUT_CYCLES, 250_000_000: duration of lockout.
- OPEN_CYCLES, 500_000_000: auto-relock timeout.
- DEBOUNCE_CYCLES, 500_000: stability window (used only with debounce compiled in).
- clk  in  1  system clock
- rst_n  in  1  synchronous active-low reset
- key_num  in  4  encoder digit code, asynchronous to clk
- enter_btn  in  1  confirm button, asynchronous, active-high
- clear_btn  in  1  clear/program button, asynchronous, active-high
- unlocked  out  1  lock released
- alarm  out  1  lockout active
- disp3..disp0  out  4 each  digit codes to decoders; disp3 is leftmost
- tries  out  2  current failed-attempt count

## Operation
- Reset values: unlocked=0, alarm=0, disp3..0=4'hF, tries=0, state ENTRY, entry buffer empty, stored code=DEFAULT_CODE.
- All inputs pass through a 2-flop synchronizer. An event pulse fires once per press, on the zero→nonzero transition of key_num or on the 0→1 transition of a button.
- Priority when events coincide in one cycle: clear > enter > key. Lower-priority events in that cycle are discarded.
- ENTRY:
  - A key event shifts the digit into disp0 and moves older digits left.
  - After 4 digits, further key events are ignored.
  - Clear empties the buffer (all 4'hF); tries is unchanged.
  - Enter → CHECK, including when the buffer holds fewer than 4 digits.
- CHECK, 1 cycle:
  - Match requires exactly 4 digits equal to the stored code.
  - On match: tries=0 → OPEN.
  - On mismatch: tries+1. If the new value equals MAX_TRIES → LOCKOUT, else → FAIL.
- FAIL: disp=EEEE; all events ignored. After FAIL_CYCLES → ENTRY with the buffer cleared.
- LOCKOUT: alarm=1, disp=AAAA; all events ignored. After LOCKOUT_CYCLES: tries=0, alarm=0 → ENTRY with the buffer cleared.
- OPEN:
  - unlocked=1, disp=0000.
  - Enter or OPEN_CYCLES expiry → ENTRY with unlocked=0.
  - Clear → PROGRAM with the buffer cleared.
- PROGRAM:
  - unlocked stays 1.
  - Digits are collected as in ENTRY; clear empties the buffer.
  - Enter with exactly 4 digits loads the buffer into the stored code → ENTRY (unlocked=0).
  - Enter with fewer than 4 digits → ENTRY; the code is unchanged.
- Timers are sized $clog2 of the largest cycle parameter and restart on each state entry. The OPEN timer does not run in PROGRAM.
- Reset mid-operation restores DEFAULT_CODE and aborts any timer.

## Timing
- All outputs are registered.
- Without debounce: key_num first sampled nonzero at edge 0 → event at edge 2 → disp updated at edge 3.
- Enter event at edge E → CHECK at E+1 → unlocked/disp/tries reflect the result at E+2.
- Timed states last exactly N cycles: the state is entered at edge T and left at edge T+N.
- Holding a key produces a single event. A new press requires key_num to return to 0 for at least 1 synchronized cycle.

## Configuration
- LOCK_DEBOUNCE_EN defined:
  - Each input must hold the same nonzero/1 value for DEBOUNCE_CYCLES consecutive synchronized cycles before the event fires; latency grows by DEBOUNCE_CYCLES.
  - Release is recognized only after the input holds 0 for DEBOUNCE_CYCLES.
  - A change in key_num value mid-window restarts the window.
- LOCK_DEBOUNCE_EN undefined: events fire on the first synchronized transition, as described under Timing.

## Structure
- Package lock_pkg: state enum (ENTRY, CHECK, FAIL, LOCKOUT, OPEN, PROGRAM); glyph constants DIGIT_BLANK=4'hF, DIGIT_ERR=4'hE, DIGIT_ALARM=4'hA, DIGIT_OPEN=4'h0.
- Sub-module btn_event, parameterised by width: synchronizer, optional debounce and edge pulse; outputs the captured value. Instantiated once for key_num (width 4) and once each for enter and clear (width 1).

## Test plan
Bench parameters: FAIL_CYCLES=4, LOCKOUT_CYCLES=20, OPEN_CYCLES=30, MAX_TRIES=3, DEBOUNCE_CYCLES=3.
- Press 1,2,3,4 then enter → disp shows FFF1, FF12, F123, 1234; unlocked=1 exactly 2 cycles after the enter event; disp=0000.
- Enter 1,2,3,5 three times → EEEE for 4 cycles after attempts 1 and 2, tries counts 1→2. The third attempt → alarm=1, AAAA for 20 cycles, then tries=0, disp=FFFF.
- Unlock, clear, press 9,8,7,6, enter; then enter 9876 → unlocked=1; entering 1234 afterwards fails.
- Key held across 10 cycles → one digit; enter and key in the same cycle → key dropped, CHECK entered.
- Unlock, idle 30 cycles → unlocked drops to 0; rst_n=0 during PROGRAM → all outputs at reset values, code 1234 restored.
- LOCK_DEBOUNCE_EN build: a 2-cycle glitch on key_num yields no digit; a 3-cycle stable press yields one digit.

Source files
------------

// File: rtl/lock_pkg.sv
// Shared state encoding and 7-segment glyph codes for the keypad lock controller.
package lock_pkg;

   typedef enum logic [2:0] {
      ENTRY,
      CHECK,
      FAIL,
      LOCKOUT,
      OPEN,
      PROGRAM
   } lock_state_t;

   localparam logic [3:0] DIGIT_BLANK = 4'hF;
   localparam logic [3:0] DIGIT_ERR   = 4'hE;
   localparam logic [3:0] DIGIT_ALARM = 4'hA;
   localparam logic [3:0] DIGIT_OPEN  = 4'h0;

   function automatic logic [15:0] fill4(input logic [3:0] glyph);
      return {4{glyph}};
   endfunction

endpackage

// File: rtl/btn_event.sv
// Input conditioner: 2-flop synchronizer, optional debounce and a one-cycle press pulse.
// Build option: LOCK_DEBOUNCE_EN enables the DEBOUNCE_CYCLES stability window.
module btn_event #(
   parameter int W               = 1,
   parameter int DEBOUNCE_CYCLES = 500_000
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic [W-1:0] din,
   output logic         pulse,
   output logic [W-1:0] value
);

   logic [W-1:0] sync_p0;
   logic [W-1:0] sync_p1;
   logic [W-1:0] level;
   logic [W-1:0] prev_p2;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         sync_p0 <= '0;
         sync_p1 <= '0;
      end else begin
         sync_p0 <= din;
         sync_p1 <= sync_p0;
      end
   end

`ifdef LOCK_DEBOUNCE_EN
   localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

   logic [W-1:0]  cand;
   logic [CW-1:0] cnt;
   logic [W-1:0]  stable;

   // cnt holds how many consecutive cycles sync_p1 has matched cand
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         cand   <= '0;
         cnt    <= '0;
         stable <= '0;
      end else if (sync_p1 != cand) begin
         cand <= sync_p1;
         cnt  <= CW'(1);
      end else if (cnt >= CW'(DEBOUNCE_CYCLES - 1)) begin
         stable <= cand;
      end else begin
         cnt <= cnt + 1'b1;
      end
   end

   assign level = stable;
`else
   logic unused_deb;

   assign unused_deb = (DEBOUNCE_CYCLES > 0);
   assign level      = sync_p1;
`endif

   // Edge stage: pulse on idle-to-pressed, value captured alongside
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         prev_p2 <= '0;
         pulse   <= 1'b0;
         value   <= '0;
      end else begin
         prev_p2 <= level;
         pulse   <= (level != '0) && (prev_p2 == '0);
         value   <= level;
      end
   end

endmodule

// File: rtl/lock_entry_ctrl.sv
// Keypad lock controller: 4-digit entry, code check, fail/lockout timing, code programming.
// Build option: LOCK_DEBOUNCE_EN adds input debouncing inside btn_event.
module lock_entry_ctrl
   import lock_pkg::*;
#(
   parameter logic [15:0] DEFAULT_CODE    = 16'h1234,
   parameter int          MAX_TRIES       = 3,
   parameter int          FAIL_CYCLES     = 25_000_000,
   parameter int          LOCKOUT_CYCLES  = 250_000_000,
   parameter int          OPEN_CYCLES     = 500_000_000,
   parameter int          DEBOUNCE_CYCLES = 500_000
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [3:0] key_num,
   input  logic       enter_btn,
   input  logic       clear_btn,
   output logic       unlocked,
   output logic       alarm,
   output logic [3:0] disp3,
   output logic [3:0] disp2,
   output logic [3:0] disp1,
   output logic [3:0] disp0,
   output logic [1:0] tries
);

   localparam int TMAX_FL = (FAIL_CYCLES > LOCKOUT_CYCLES) ? FAIL_CYCLES : LOCKOUT_CYCLES;
   localparam int TMAX    = (TMAX_FL > OPEN_CYCLES) ? TMAX_FL : OPEN_CYCLES;
   localparam int TW      = (TMAX > 1) ? $clog2(TMAX) : 1;

   localparam logic [TW-1:0] FAIL_LAST    = TW'(FAIL_CYCLES - 1);
   localparam logic [TW-1:0] LOCKOUT_LAST = TW'(LOCKOUT_CYCLES - 1);
   localparam logic [TW-1:0] OPEN_LAST    = TW'(OPEN_CYCLES - 1);
   localparam logic [1:0]    TRIES_LIMIT  = 2'(MAX_TRIES);

   logic        key_ev;
   logic [3:0]  key_val;
   logic        ent_ev;
   logic        clr_ev;
   logic [0:0]  unused_ent_val;
   logic [0:0]  unused_clr_val;

   btn_event #(.W(4), .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_key (
      .clk   (clk),
      .rst_n (rst_n),
      .din   (key_num),
      .pulse (key_ev),
      .value (key_val)
   );

   btn_event #(.W(1), .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_enter (
      .clk   (clk),
      .rst_n (rst_n),
      .din   (enter_btn),
      .pulse (ent_ev),
      .value (unused_ent_val)
   );

   btn_event #(.W(1), .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_clear (
      .clk   (clk),
      .rst_n (rst_n),
      .din   (clear_btn),
      .pulse (clr_ev),
      .value (unused_clr_val)
   );

   lock_state_t   state;
   logic [TW-1:0] timer;
   logic [15:0]   dreg;
   logic [2:0]    cnt;
   logic [15:0]   code;
   logic [1:0]    tries_nx;

   assign tries_nx = tries + 2'd1;

   // dreg doubles as the entry buffer in ENTRY/PROGRAM/CHECK and as the glyph register elsewhere
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state    <= ENTRY;
         timer    <= '0;
         dreg     <= fill4(DIGIT_BLANK);
         cnt      <= '0;
         code     <= DEFAULT_CODE;
         tries    <= '0;
         unlocked <= 1'b0;
         alarm    <= 1'b0;
      end else begin
         case (state)
            ENTRY, PROGRAM: begin
               if (clr_ev) begin
                  dreg <= fill4(DIGIT_BLANK);
                  cnt  <= '0;
               end else if (ent_ev) begin
                  if (state == ENTRY) begin
                     state <= CHECK;
                  end else begin
                     if (cnt == 3'd4) code <= dreg;
                     state    <= ENTRY;
                     unlocked <= 1'b0;
                     dreg     <= fill4(DIGIT_BLANK);
                     cnt      <= '0;
                  end
               end else if (key_ev && (cnt != 3'd4)) begin
                  dreg <= {dreg[11:0], key_val};
                  cnt  <= cnt + 3'd1;
               end
            end
            CHECK: begin
               timer <= '0;
               cnt   <= '0;
               if ((cnt == 3'd4) && (dreg == code)) begin
                  tries    <= '0;
                  unlocked <= 1'b1;
                  dreg     <= fill4(DIGIT_OPEN);
                  state    <= OPEN;
               end else begin
                  tries <= tries_nx;
                  if (tries_nx == TRIES_LIMIT) begin
                     alarm <= 1'b1;
                     dreg  <= fill4(DIGIT_ALARM);
                     state <= LOCKOUT;
                  end else begin
                     dreg  <= fill4(DIGIT_ERR);
                     state <= FAIL;
                  end
               end
            end
            FAIL: begin
               timer <= timer + 1'b1;
               if (timer == FAIL_LAST) begin
                  dreg  <= fill4(DIGIT_BLANK);
                  state <= ENTRY;
               end
            end
            LOCKOUT: begin
               timer <= timer + 1'b1;
               if (timer == LOCKOUT_LAST) begin
                  tries <= '0;
                  alarm <= 1'b0;
                  dreg  <= fill4(DIGIT_BLANK);
                  state <= ENTRY;
               end
            end
            OPEN: begin
               timer <= timer + 1'b1;
               if (clr_ev) begin
                  dreg  <= fill4(DIGIT_BLANK);
                  cnt   <= '0;
                  state <= PROGRAM;
               end else if (ent_ev || (timer == OPEN_LAST)) begin
                  unlocked <= 1'b0;
                  dreg     <= fill4(DIGIT_BLANK);
                  cnt      <= '0;
                  state    <= ENTRY;
               end
            end
            default: state <= ENTRY;
         endcase
      end
   end

   assign disp3 = dreg[15:12];
   assign disp2 = dreg[11:8];
   assign disp1 = dreg[7:4];
   assign disp0 = dreg[3:0];

endmodule

// File: tb/tb_lock_entry_ctrl.sv
// Self-checking bench for lock_entry_ctrl: vector table, directed timing sequences and
// randomized operations against an event-level reference model (debounce build: glitch tests).
`timescale 1ns/1ps
module tb_lock_entry_ctrl;

   localparam int FAIL_N = 4;
   localparam int LOCK_N = 20;
   localparam int OPEN_N = 30;
   localparam int MAXT   = 3;
   localparam int DEB_N  = 3;

   localparam int EV_NONE = 0;
   localparam int EV_KEY  = 1;
   localparam int EV_ENT  = 2;
   localparam int EV_CLR  = 3;

   localparam int M_ENTRY = 0;
   localparam int M_CHECK = 1;
   localparam int M_FAIL  = 2;
   localparam int M_LOCK  = 3;
   localparam int M_OPEN  = 4;
   localparam int M_PROG  = 5;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [3:0] key_num = 4'd0;
   logic       enter_btn = 1'b0;
   logic       clear_btn = 1'b0;
   logic       unlocked;
   logic       alarm;
   logic [3:0] disp3, disp2, disp1, disp0;
   logic [1:0] tries;
   logic [15:0] disp;

   assign disp = {disp3, disp2, disp1, disp0};

   lock_entry_ctrl #(
      .DEFAULT_CODE    (16'h1234),
      .MAX_TRIES       (MAXT),
      .FAIL_CYCLES     (FAIL_N),
      .LOCKOUT_CYCLES  (LOCK_N),
      .OPEN_CYCLES     (OPEN_N),
      .DEBOUNCE_CYCLES (DEB_N)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .key_num   (key_num),
      .enter_btn (enter_btn),
      .clear_btn (clear_btn),
      .unlocked  (unlocked),
      .alarm     (alarm),
      .disp3     (disp3),
      .disp2     (disp2),
      .disp1     (disp1),
      .disp0     (disp0),
      .tries     (tries)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   bit model_on = 1'b0;

   // reference model: event-level view of the lock
   typedef struct { int at; int kind; int val; } ev_t;
   ev_t pend[$];
   int  ms;
   int  mdead;
   int  mtries;
   int  mcode[4];
   int  mdig[$];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic model_reset();
      pend.delete();
      mdig.delete();
      ms = M_ENTRY;
      mdead = 0;
      mtries = 0;
      mcode[0] = 1; mcode[1] = 2; mcode[2] = 3; mcode[3] = 4;
   endtask

   task automatic model_step();
      int kind;
      int val;
      bit match;
      kind = EV_NONE;
      val = 0;
      for (int i = 0; i < pend.size(); i++) begin
         if (pend[i].at == cyc) begin
            kind = pend[i].kind;
            val = pend[i].val;
            pend.delete(i);
            break;
         end
      end
      if (ms != M_ENTRY && ms != M_PROG && cyc == mdead) begin
         if (ms == M_OPEN && kind == EV_CLR) begin
            ms = M_PROG;
            mdig.delete();
         end else if (ms == M_CHECK) begin
            match = (mdig.size() == 4);
            if (match) for (int i = 0; i < 4; i++) if (mdig[i] != mcode[i]) match = 1'b0;
            if (match) begin
               mtries = 0;
               ms = M_OPEN;
               mdead = cyc + OPEN_N;
            end else begin
               mtries++;
               ms = (mtries == MAXT) ? M_LOCK : M_FAIL;
               mdead = cyc + ((mtries == MAXT) ? LOCK_N : FAIL_N);
            end
         end else begin
            if (ms == M_LOCK) mtries = 0;
            ms = M_ENTRY;
            mdig.delete();
         end
      end else if (kind != EV_NONE) begin
         if (ms == M_ENTRY || ms == M_PROG) begin
            if (kind == EV_CLR) mdig.delete();
            else if (kind == EV_KEY) begin
               if (mdig.size() < 4) mdig.push_back(val);
            end else if (ms == M_ENTRY) begin
               ms = M_CHECK;
               mdead = cyc + 1;
            end else begin
               if (mdig.size() == 4) for (int i = 0; i < 4; i++) mcode[i] = mdig[i];
               ms = M_ENTRY;
               mdig.delete();
            end
         end else if (ms == M_OPEN) begin
            if (kind == EV_CLR) begin
               ms = M_PROG;
               mdig.delete();
            end else if (kind == EV_ENT) begin
               ms = M_ENTRY;
               mdig.delete();
            end
         end
      end
   endtask

   task automatic model_check();
      logic [15:0] ed;
      logic        eu, ea;
      logic [1:0]  et;
      int          n;
      case (ms)
         M_FAIL: ed = 16'hEEEE;
         M_LOCK: ed = 16'hAAAA;
         M_OPEN: ed = 16'h0000;
         default: begin
            ed = 16'hFFFF;
            n = mdig.size();
            for (int i = 0; i < n; i++) ed[4*(n-1-i) +: 4] = 4'(mdig[i]);
         end
      endcase
      eu = (ms == M_OPEN) || (ms == M_PROG);
      ea = (ms == M_LOCK);
      et = 2'(mtries);
      chk("random_model", {11'd0, unlocked, alarm, tries, disp}, {11'd0, eu, ea, et, ed});
   endtask

   task automatic tick();
      @(posedge clk);
      cyc++;
      model_step();
      @(negedge clk);
      if (model_on) model_check();
   endtask

   task automatic post(input int kind, input int val);
      ev_t e;
      e.at = cyc + 4;
      e.kind = kind;
      e.val = val;
      pend.push_back(e);
   endtask

   task automatic do_reset();
      model_reset();
      key_num = 4'd0;
      enter_btn = 1'b0;
      clear_btn = 1'b0;
      rst_n = 1'b0;
      tick();
      tick();
      rst_n = 1'b1;
   endtask

   task automatic press_key(input logic [3:0] v, input int hold);
      key_num = v;
      post(EV_KEY, int'(v));
      repeat (hold) tick();
      key_num = 4'd0;
      repeat (2) tick();
   endtask

   task automatic press_btn(input int which);
      if (which == EV_ENT) enter_btn = 1'b1;
      else clear_btn = 1'b1;
      post(which, 0);
      repeat (2) tick();
      enter_btn = 1'b0;
      clear_btn = 1'b0;
      repeat (2) tick();
   endtask

   task automatic enter_code(input logic [15:0] c);
      logic [15:0] t;
      t = c;
      for (int i = 3; i >= 0; i--) press_key(t[4*i +: 4], 2);
   endtask

   task automatic chk_reset_vals(input string name);
      chk({name, "_unlocked"}, {31'd0, unlocked}, 32'd0);
      chk({name, "_alarm"}, {31'd0, alarm}, 32'd0);
      chk({name, "_disp"}, {16'd0, disp}, 32'h0000FFFF);
      chk({name, "_tries"}, {30'd0, tries}, 32'd0);
   endtask

   typedef struct {
      logic [19:0] digs;
      int          n;
      logic [15:0] exp_pre;
      logic        exp_unl;
      logic [15:0] exp_post;
      logic [1:0]  exp_tries;
   } vec_t;

   vec_t vecs[7];

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation time limit reached, checks=%0d", checks);
      $fatal(1, "watchdog");
   end

   initial begin
      vecs[0] = '{20'h12340, 4, 16'h1234, 1'b1, 16'h0000, 2'd0};
      vecs[1] = '{20'h12300, 3, 16'hF123, 1'b0, 16'hEEEE, 2'd1};
      vecs[2] = '{20'h12350, 4, 16'h1235, 1'b0, 16'hEEEE, 2'd1};
      vecs[3] = '{20'h12345, 5, 16'h1234, 1'b1, 16'h0000, 2'd0};
      vecs[4] = '{20'h91234, 5, 16'h9123, 1'b0, 16'hEEEE, 2'd1};
      vecs[5] = '{20'h00000, 0, 16'hFFFF, 1'b0, 16'hEEEE, 2'd1};
      vecs[6] = '{20'h43210, 4, 16'h4321, 1'b0, 16'hEEEE, 2'd1};

      do_reset();
      chk_reset_vals("reset");

`ifdef LOCK_DEBOUNCE_EN
      // 2-cycle glitch must not register
      key_num = 4'd7;
      repeat (2) tick();
      key_num = 4'd0;
      repeat (15) tick();
      chk("deb_glitch", {16'd0, disp}, 32'h0000FFFF);
      // 3-cycle stable press registers once
      key_num = 4'd5;
      repeat (3) tick();
      key_num = 4'd0;
      repeat (15) tick();
      chk("deb_press", {16'd0, disp}, 32'h0000FFF5);
      key_num = 4'd6;
      repeat (8) tick();
      key_num = 4'd0;
      repeat (15) tick();
      chk("deb_second", {16'd0, disp}, 32'h0000FF56);
      // short release gap is not a new press
      key_num = 4'd6;
      repeat (6) tick();
      key_num = 4'd0;
      repeat (2) tick();
      key_num = 4'd6;
      repeat (6) tick();
      key_num = 4'd0;
      repeat (15) tick();
      chk("deb_short_gap", {16'd0, disp}, 32'h0000F566);
`else
      // table: reset, type digits, enter, check result two cycles after the enter event
      for (int v = 0; v < 7; v++) begin
         do_reset();
         for (int i = 0; i < vecs[v].n; i++) press_key(vecs[v].digs[4*(4-i) +: 4], 2);
         chk($sformatf("vec%0d_pre", v), {16'd0, disp}, {16'd0, vecs[v].exp_pre});
         press_btn(EV_ENT);
         tick();
         chk($sformatf("vec%0d_unlocked", v), {31'd0, unlocked}, {31'd0, vecs[v].exp_unl});
         chk($sformatf("vec%0d_disp", v), {16'd0, disp}, {16'd0, vecs[v].exp_post});
         chk($sformatf("vec%0d_tries", v), {30'd0, tries}, {30'd0, vecs[v].exp_tries});
      end

      // key latency: sampled at edge 0, display at edge 3
      do_reset();
      key_num = 4'd1;
      repeat (3) tick();
      chk("lat_before", {16'd0, disp}, 32'h0000FFFF);
      tick();
      chk("lat_fff1", {16'd0, disp}, 32'h0000FFF1);
      key_num = 4'd0;
      repeat (2) tick();
      press_key(4'd2, 2);
      chk("seq_ff12", {16'd0, disp}, 32'h0000FF12);
      press_key(4'd3, 2);
      chk("seq_f123", {16'd0, disp}, 32'h0000F123);
      press_key(4'd4, 2);
      chk("seq_1234", {16'd0, disp}, 32'h00001234);
      press_btn(EV_ENT);
      chk("check_cycle_locked", {31'd0, unlocked}, 32'd0);
      tick();
      chk("open_unlocked", {31'd0, unlocked}, 32'd1);
      chk("open_disp", {16'd0, disp}, 32'h00000000);

      // three failures: EEEE for exactly FAIL_N cycles, then lockout for LOCK_N
      do_reset();
      for (int a = 1; a <= 3; a++) begin
         enter_code(16'h1235);
         press_btn(EV_ENT);
         tick();
         if (a < 3) begin
            chk($sformatf("fail%0d_disp", a), {16'd0, disp}, 32'h0000EEEE);
            chk($sformatf("fail%0d_tries", a), {30'd0, tries}, a);
            repeat (FAIL_N - 1) tick();
            chk($sformatf("fail%0d_last", a), {16'd0, disp}, 32'h0000EEEE);
            tick();
            chk($sformatf("fail%0d_exit", a), {16'd0, disp}, 32'h0000FFFF);
         end else begin
            chk("lock_alarm", {31'd0, alarm}, 32'd1);
            chk("lock_disp", {16'd0, disp}, 32'h0000AAAA);
            repeat (LOCK_N - 1) tick();
            chk("lock_last", {15'd0, alarm, disp}, 32'h0001AAAA);
            tick();
            chk("lock_exit", {13'd0, alarm, tries, disp}, 32'h0000FFFF);
         end
      end

      // program a new code, then use it; the old code no longer opens
      do_reset();
      enter_code(16'h1234);
      press_btn(EV_ENT);
      tick();
      press_btn(EV_CLR);
      chk("prog_enter", {15'd0, unlocked, disp}, 32'h0001FFFF);
      enter_code(16'h9876);
      chk("prog_digits", {15'd0, unlocked, disp}, 32'h00019876);
      press_btn(EV_ENT);
      chk("prog_exit", {15'd0, unlocked, disp}, 32'h0000FFFF);
      enter_code(16'h9876);
      press_btn(EV_ENT);
      tick();
      chk("new_code_opens", {31'd0, unlocked}, 32'd1);
      press_btn(EV_ENT);
      chk("relock_enter", {31'd0, unlocked}, 32'd0);
      enter_code(16'h1234);
      press_btn(EV_ENT);
      tick();
      chk("old_code_fails", {15'd0, unlocked, disp}, 32'h0000EEEE);
      repeat (FAIL_N) tick();

      // held key gives one digit; enter and key together: key dropped
      do_reset();
      press_key(4'd7, 10);
      repeat (2) tick();
      chk("held_key", {16'd0, disp}, 32'h0000FFF7);
      press_key(4'd1, 2);
      press_key(4'd2, 2);
      key_num = 4'd3;
      enter_btn = 1'b1;
      repeat (2) tick();
      key_num = 4'd0;
      enter_btn = 1'b0;
      repeat (2) tick();
      chk("coincide_check", {16'd0, disp}, 32'h0000F712);
      tick();
      chk("coincide_fail", {14'd0, tries, disp}, 32'h0001EEEE);
      repeat (FAIL_N) tick();

      // auto-relock after OPEN_N cycles
      do_reset();
      enter_code(16'h1234);
      press_btn(EV_ENT);
      tick();
      repeat (OPEN_N - 1) tick();
      chk("open_last", {31'd0, unlocked}, 32'd1);
      tick();
      chk("open_timeout", {15'd0, unlocked, disp}, 32'h0000FFFF);

      // reset during PROGRAM restores outputs and the default code
      do_reset();
      enter_code(16'h1234);
      press_btn(EV_ENT);
      tick();
      press_btn(EV_CLR);
      press_key(4'd5, 2);
      press_key(4'd5, 2);
      chk("prog_partial", {15'd0, unlocked, disp}, 32'h0001FF55);
      rst_n = 1'b0;
      tick();
      chk_reset_vals("midreset");
      rst_n = 1'b1;
      model_reset();
      enter_code(16'h1234);
      press_btn(EV_ENT);
      tick();
      chk("default_restored", {31'd0, unlocked}, 32'd1);

      // randomized operations against the reference model, checked every cycle
      do_reset();
      model_on = 1'b1;
      for (int op = 0; op < 220; op++) begin
         int r;
         r = $urandom_range(0, 11);
         if (r <= 4) press_key(4'($urandom_range(1, 9)), $urandom_range(1, 3));
         else if (r <= 6) press_btn(EV_ENT);
         else if (r == 7) press_btn(EV_CLR);
         else if (r <= 9) begin
            for (int i = 0; i < 4; i++) press_key(4'(mcode[i]), 2);
            if (r == 9) press_btn(EV_ENT);
         end else begin
            repeat ($urandom_range(1, 35)) tick();
         end
      end
      repeat (40) tick();
      model_on = 1'b0;
`endif

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
